// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM states and width helpers.
// Also used by other top-level schedulers.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int c);
    return $clog2(c + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_encoder.sv
// Round-robin priority encoder: first set request at/after ptr, wrapping.
// Purely combinational.
module rr_priority_encoder #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    any = |req;
    // Scan from farthest to nearest so the nearest hit wins
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among N_REQ byte sources.
// Define UART_ARB_LOCK_EN to hold the grant until a req_last byte is sent.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic [idx_w(N_REQ)-1:0]   grant_id,
  output logic                      active,
  output logic                      timeout_err
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = cnt_w(TIMEOUT_CYC);

  arb_state_t state_q, state_d;

  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_nxt;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win_gnt;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt_q;
  logic [CW-1:0]    cnt_q;
  logic             any;
  logic             tmo;
  logic             done;

`ifdef UART_ARB_LOCK_EN
  logic lock_q;
  logic last_q;

  // While locked only the owner may win
  assign arb_req = lock_q ? (req_valid & gnt_q) : req_valid;
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign arb_req     = req_valid;
`endif

  rr_priority_encoder #(
    .N  (N_REQ),
    .IW (IW)
  ) u_enc (
    .req (arb_req),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (any)
  );

  always_comb begin
    state_d = state_q;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE:    if (any) state_d = START;
      START:   state_d = WAIT_HI;
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_LO: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done    = (state_q == WAIT_LO && !tx_busy) || tmo;
  assign ptr_nxt = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  assign tx_start    = (state_q == START);
  assign req_ready   = (state_q == START) ? gnt_q : '0;
  assign active      = (state_q != IDLE);
  assign timeout_err = tmo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      tx_data  <= '0;
      grant_id <= '0;
      gnt_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_q   <= 1'b0;
      last_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == WAIT_HI) ? cnt_q + 1'b1 : '0;
      if (state_q == IDLE && any) begin
        tx_data  <= req_data[win_idx*DATA_W +: DATA_W];
        grant_id <= win_idx;
        gnt_q    <= win_gnt;
`ifdef UART_ARB_LOCK_EN
        last_q   <= req_last[win_idx];
`endif
      end
`ifdef UART_ARB_LOCK_EN
      if (state_q == START) lock_q <= !last_q;
      if (tmo) lock_q <= 1'b0;
      // Pointer stays frozen while a packet owns the grant
      if (done && (!lock_q || tmo)) ptr_q <= ptr_nxt;
`else
      if (done) ptr_q <= ptr_nxt;
`endif
    end
  end

endmodule
